// File: rtl/text_cell_renderer_if.sv
// Request, glyph-decoder and framebuffer-write signal bundle of the text cell renderer.
// The renderer connects through the slave modport; its surroundings use the master modport.
interface text_cell_renderer_if #(
  parameter int COL_W    = 5,
  parameter int ROW_W    = 3,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic                req_valid;
  logic                req_ready;
  logic [6:0]          req_char;
  logic [COL_W-1:0]    req_col;
  logic [ROW_W-1:0]    req_row;
  logic [COLOUR_W-1:0] req_fg;
  logic [COLOUR_W-1:0] req_bg;
  logic                req_transp;
  logic [6:0]          dec_char;
  logic [127:0]        dec_pixels;
  logic [X_W-1:0]      fb_x;
  logic [Y_W-1:0]      fb_y;
  logic [COLOUR_W-1:0] fb_colour;
  logic                fb_write;
  logic                done;
  logic                err;

  modport master (
    output req_valid, req_char, req_col, req_row, req_fg, req_bg, req_transp, dec_pixels,
    input  req_ready, dec_char, fb_x, fb_y, fb_colour, fb_write, done, err
  );

  modport slave (
    input  req_valid, req_char, req_col, req_row, req_fg, req_bg, req_transp, dec_pixels,
    output req_ready, dec_char, fb_x, fb_y, fb_colour, fb_write, done, err
  );
endinterface

// File: rtl/text_cell_renderer.sv
// Draws one 8x16 character cell into the framebuffer per accepted request,
// one pixel per cycle, from the glyph returned by an external decoder.
module text_cell_renderer #(
  parameter int COLS     = 20,
  parameter int ROWS     = 7,
  parameter int COL_W    = 5,
  parameter int ROW_W    = 3,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input logic                 clk,
  input logic                 resetn,
  text_cell_renderer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [COL_W:0] COL_LIM = (COL_W+1)'(COLS);
  localparam logic [ROW_W:0] ROW_LIM = (ROW_W+1)'(ROWS);
  localparam logic [6:0]     LAST_PX = 7'd127;

  state_t              state_q;
  state_t              state_d;
  logic                accept;
  logic                in_range;
  logic [6:0]          dec_char_q;
  logic                err_q;

  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic [COLOUR_W-1:0] fg_q;
  logic [COLOUR_W-1:0] bg_q;
  logic                transp_q;
  logic [127:0]        glyph_q;

  logic [6:0]          px_idx_p0;
  logic                vld_p0;
  logic                bit_p0;
  logic [X_W-1:0]      x_p0;
  logic [Y_W-1:0]      y_p0;
  logic [COLOUR_W-1:0] colour_p0;

  logic                vld_p1;
  logic [X_W-1:0]      fb_x_p1;
  logic [Y_W-1:0]      fb_y_p1;
  logic [COLOUR_W-1:0] fb_colour_p1;
  logic                done_q;
  logic                done_err_q;

  assign in_range = ({1'b0, bus.req_col} < COL_LIM) && ({1'b0, bus.req_row} < ROW_LIM);
  assign accept   = bus.req_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) state_d = in_range ? LOAD : DONE;
      LOAD: state_d = DRAW;
      DRAW: if (px_idx_p0 == LAST_PX) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      px_idx_p0  <= '0;
      dec_char_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q <= ~in_range;
        // Rejected cells leave the decoder pointing at the last drawn char.
        if (in_range) dec_char_q <= bus.req_char;
      end
      if (state_q == LOAD)      px_idx_p0 <= '0;
      else if (state_q == DRAW) px_idx_p0 <= px_idx_p0 + 7'd1;
    end
  end

  // Request fields and glyph are pure data, captured at accept and at the end of LOAD.
  always_ff @(posedge clk) begin
    if (accept) begin
      col_q    <= bus.req_col;
      row_q    <= bus.req_row;
      fg_q     <= bus.req_fg;
      bg_q     <= bus.req_bg;
      transp_q <= bus.req_transp;
    end
    if (state_q == LOAD) glyph_q <= bus.dec_pixels;
  end

  // ---- stage p0: pixel address and glyph bit for px_idx ----
  assign vld_p0    = (state_q == DRAW);
  assign bit_p0    = glyph_q[LAST_PX - px_idx_p0];
  assign x_p0      = X_W'({col_q, px_idx_p0[2:0]});
  assign y_p0      = Y_W'({row_q, px_idx_p0[6:3]});
  assign colour_p0 = bit_p0 ? fg_q : bg_q;

  // ---- stage p1: registered framebuffer write and completion flags ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1       <= 1'b0;
      fb_x_p1      <= '0;
      fb_y_p1      <= '0;
      fb_colour_p1 <= '0;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      vld_p1     <= vld_p0 && (bit_p0 || !transp_q);
      done_q     <= (state_q == DONE);
      done_err_q <= (state_q == DONE) && err_q;
      if (vld_p0) begin
        fb_x_p1      <= x_p0;
        fb_y_p1      <= y_p0;
        fb_colour_p1 <= colour_p0;
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.dec_char  = dec_char_q;
  assign bus.fb_x      = fb_x_p1;
  assign bus.fb_y      = fb_y_p1;
  assign bus.fb_colour = fb_colour_p1;
  assign bus.fb_write  = vld_p1;
  assign bus.done      = done_q;
  assign bus.err       = done_err_q;

endmodule

// File: tb/tb_text_cell_renderer.sv
// Bench for text_cell_renderer: a cycle-indexed pixel schedule model plus directed requests.
module tb_text_cell_renderer;
  localparam int COLS = 20, ROWS = 7, COL_W = 5, ROW_W = 3, X_W = 8, Y_W = 7, COLOUR_W = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  text_cell_renderer_if #(.COL_W(COL_W), .ROW_W(ROW_W), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) bus ();

  text_cell_renderer #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W),
                       .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W))
    dut (.clk(clk), .resetn(resetn), .bus(bus));

  // Font rows, MSB = leftmost pixel. 'A' has 38 set pixels, first at row 2, column 2.
  function automatic logic [7:0] font_row(input logic [6:0] c, input int r);
    logic [7:0] v;
    v = 8'h00;
    case (c)
      7'h41: case (r)
               2: v = 8'h38;
               3: v = 8'h6C;
               4, 5, 7, 8, 9, 10: v = 8'hC6;
               6: v = 8'hFE;
               default: v = 8'h00;
             endcase
      7'h20: v = 8'h00;
      default: v = {1'b1, c} ^ 8'(r);
    endcase
    return v;
  endfunction

  function automatic logic [127:0] font(input logic [6:0] c);
    logic [127:0] g;
    g = '0;
    for (int r = 0; r < 16; r++) g[127-8*r -: 8] = font_row(c, r);
    return g;
  endfunction

  assign bus.dec_pixels = font(bus.dec_char);

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] c;
  } wr_t;

  wr_t exp_wr [int];
  bit  exp_done [int];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  int wr_count, first_x, first_y, last_x, last_y, n_c7, done_cnt, last_done_cyc, last_done_err;
  int pix_log [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected writes and done pulse for a request accepted at clock edge e.
  task automatic model_request(input int e, input logic [6:0] ch, input int col, input int row,
                               input int fg, input int bg, input bit tr);
    logic [7:0] r8;
    bit b;
    if (col >= COLS || row >= ROWS) begin
      exp_done[e+1] = 1'b1;
      return;
    end
    for (int py = 0; py < 16; py++) begin
      r8 = font_row(ch, py);
      for (int px = 0; px < 8; px++) begin
        b = r8[7-px];
        if (b || !tr)
          exp_wr[e + 2 + py*8 + px] = '{x: X_W'(col*8 + px), y: Y_W'(row*16 + py),
                                        c: COLOUR_W'(b ? fg : bg)};
      end
    end
    exp_done[e+130] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_wr.exists(cyc)) begin
      check("fb_write", int'(bus.fb_write), 1);
      check("fb_x", int'(bus.fb_x), int'(exp_wr[cyc].x));
      check("fb_y", int'(bus.fb_y), int'(exp_wr[cyc].y));
      check("fb_colour", int'(bus.fb_colour), int'(exp_wr[cyc].c));
    end else begin
      check("fb_write_quiet", int'(bus.fb_write), 0);
    end
    if (exp_done.exists(cyc)) begin
      check("done", int'(bus.done), 1);
      check("err", int'(bus.err), int'(exp_done[cyc]));
    end else begin
      check("done_quiet", int'(bus.done), 0);
      check("err_quiet", int'(bus.err), 0);
    end
    if (bus.fb_write) begin
      if (wr_count == 0) begin
        first_x = int'(bus.fb_x);
        first_y = int'(bus.fb_y);
      end
      last_x = int'(bus.fb_x);
      last_y = int'(bus.fb_y);
      wr_count++;
      pix_log[int'(bus.fb_x)*256 + int'(bus.fb_y)] = int'(bus.fb_colour);
      if (bus.fb_colour == 3'd7) n_c7++;
    end
    if (bus.done) begin
      done_cnt++;
      last_done_cyc = cyc;
      last_done_err = int'(bus.err);
    end
  end

  task automatic clear_log();
    wr_count = 0; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    n_c7 = 0; done_cnt = 0; last_done_cyc = -1; last_done_err = -1;
    pix_log.delete();
  endtask

  function automatic int logged(input int x, input int y);
    return pix_log.exists(x*256 + y) ? pix_log[x*256 + y] : -1;
  endfunction

  // Presents a request at a falling edge and returns the clock edge on which it was taken.
  task automatic send(input logic [6:0] ch, input int col, input int row, input int fg,
                      input int bg, input bit tr, input bit keep, output int e);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.req_char   = ch;
    bus.req_col    = COL_W'(col);
    bus.req_row    = ROW_W'(row);
    bus.req_fg     = COLOUR_W'(fg);
    bus.req_bg     = COLOUR_W'(bg);
    bus.req_transp = tr;
    bus.req_valid  = 1'b1;
    while (bus.req_ready !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 400) begin
      check("accept_timeout", waited, 0);
      bus.req_valid = 1'b0;
      e = -1;
      return;
    end
    e = cyc + 1;
    model_request(e, ch, col, row, fg, bg, tr);
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int e, e2;
    int keys[$];
    bus.req_valid = 1'b0; bus.req_char = '0; bus.req_col = '0; bus.req_row = '0;
    bus.req_fg = '0; bus.req_bg = '0; bus.req_transp = 1'b0;
    clear_log();
    #1;
    check("rst_req_ready", int'(bus.req_ready), 1);
    check("rst_fb_write", int'(bus.fb_write), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_dec_char", int'(bus.dec_char), 0);
    check("rst_fb_xy", int'(bus.fb_x) + int'(bus.fb_y) + int'(bus.fb_colour), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // 'A' opaque at cell (1,0)
    clear_log();
    send(7'h41, 1, 0, 7, 0, 1'b0, 1'b0, e);
    check("t1_dec_char", int'(bus.dec_char), 8'h41);
    wait_until(e + 133);
    check("t1_writes", wr_count, 128);
    check("t1_px_10_2", logged(10, 2), 7);
    check("t1_px_8_0", logged(8, 0), 0);
    check("t1_first_xy", first_x*256 + first_y, 8*256 + 0);
    check("t1_last_xy", last_x*256 + last_y, 15*256 + 15);
    check("t1_done_cyc", last_done_cyc - e, 130);

    // 'A' transparent
    clear_log();
    send(7'h41, 1, 0, 7, 0, 1'b1, 1'b0, e);
    wait_until(e + 133);
    check("t2_writes", wr_count, 38);
    check("t2_fg_writes", n_c7, 38);
    check("t2_first_xy", first_x*256 + first_y, 10*256 + 2);

    // space, transparent, bottom-right cell
    clear_log();
    send(7'h20, 19, 6, 5, 3, 1'b1, 1'b0, e);
    wait_until(e + 133);
    check("t3_writes", wr_count, 0);
    check("t3_done_cyc", last_done_cyc - e, 130);
    check("t3_err", last_done_err, 0);

    // space, opaque, bottom-right cell reaches the far framebuffer corner
    clear_log();
    send(7'h20, 19, 6, 1, 4, 1'b0, 1'b0, e);
    wait_until(e + 133);
    check("t3b_writes", wr_count, 128);
    check("t3b_corner", logged(159, 111), 4);

    // out-of-range column, then out-of-range row
    clear_log();
    send(7'h55, 20, 0, 7, 0, 1'b0, 1'b0, e);
    check("t4_dec_char", int'(bus.dec_char), 8'h20);
    wait_until(e + 5);
    check("t4_done_cyc", last_done_cyc - e, 1);
    check("t4_err", last_done_err, 1);
    check("t4_writes", wr_count, 0);
    clear_log();
    send(7'h56, 0, 7, 7, 0, 1'b0, 1'b0, e);
    wait_until(e + 5);
    check("t4b_done_cyc", last_done_cyc - e, 1);
    check("t4b_err", last_done_err, 1);
    check("t4b_dec_char", int'(bus.dec_char), 8'h20);

    // back-to-back 'H' then 'i' with req_valid held high
    clear_log();
    send(7'h48, 0, 0, 2, 1, 1'b0, 1'b1, e);
    send(7'h69, 1, 0, 6, 3, 1'b0, 1'b0, e2);
    check("t5_accept_gap", e2 - e, 131);
    check("t5_dec_char", int'(bus.dec_char), 8'h69);
    wait_until(e2 + 133);
    check("t5_writes", wr_count, 256);
    check("t5_first_x", first_x, 0);
    check("t5_last_x", last_x, 15);
    check("t5_dones", done_cnt, 2);

    // reset while drawing at px_idx 50
    clear_log();
    send(7'h41, 2, 3, 5, 2, 1'b0, 1'b0, e);
    wait_until(e + 51);
    #2;
    resetn = 1'b0;
    keys.delete();
    foreach (exp_wr[k]) if (k > cyc) keys.push_back(k);
    foreach (keys[i]) exp_wr.delete(keys[i]);
    keys.delete();
    foreach (exp_done[k]) if (k > cyc) keys.push_back(k);
    foreach (keys[i]) exp_done.delete(keys[i]);
    #1;
    check("t6_fb_write_drop", int'(bus.fb_write), 0);
    check("t6_req_ready", int'(bus.req_ready), 1);
    check("t6_dec_char", int'(bus.dec_char), 0);
    check("t6_partial_writes", wr_count, 50);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    wait_until(e + 200);
    check("t6_no_done", done_cnt, 0);
    clear_log();
    send(7'h48, 4, 1, 6, 1, 1'b0, 1'b0, e);
    wait_until(e + 133);
    check("t6_redraw_writes", wr_count, 128);
    check("t6_redraw_done", last_done_cyc - e, 130);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
